pic_int_sequencer: RTL and testbench
====================================

Name: pic_int_sequencer

Overview:
- Interrupt sequencing controller for the 8259-style PIC.
- Takes the IRR block output and the IMR, and resolves priority against the in-service register (ISR).
- Drives INT, runs the two-pulse INTA handshake, sets and clears ISR bits, and supplies the interrupt vector byte.
- Sits between the IRR block, the control/command logic (ICW/OCW decode) and the data-bus buffer.

Parameters:
- RESET_LOWEST, 3'd7, reset value of the lowest-priority pointer; 7 gives fixed order IR0 highest.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- IRR  in  8  pending requests from IRR block
- Mask  in  8  IMR; 1 = level masked
- vector_base  in  5  T7..T3 from ICW2
- aeoi  in  1  automatic-EOI mode
- rot_aeoi  in  1  rotate priority on automatic EOI
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI using eoi_level
- eoi_level  in  3  level for specific EOI
- eoi_rotate  in  1  rotate priority with this EOI
- inta_n  in  1  interrupt acknowledge, active low, already synchronised to clk
- INT  out  1  interrupt request to CPU
- irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- ISR  out  8  in-service register
- data_out  out  8  vector byte
- data_oe  out  1  data_out valid, drive bus

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - ISR=0, INT=0, irr_clear=0, data_out=0, data_oe=0.
  - lowest=RESET_LOWEST, inta_prev=1, state=IDLE.
- Priority order: (lowest+1) mod 8 is highest, descending cyclically to lowest.
- Request and in-service levels:
  - req = IRR & ~Mask.
  - pend_hi = highest-priority bit of req.
  - isr_hi = highest-priority bit of ISR; ISR is not masked.
  - pending = req nonzero AND (ISR zero OR pend_hi strictly higher priority than isr_hi).
- INTA edge detection: inta_fall = inta_prev & ~inta_n; inta_rise = ~inta_prev & inta_n. inta_prev is registered every cycle.
- All outputs are registered.
- FSM:
  - IDLE: INT=0. If pending, go to REQ, so INT=1 one cycle after pending. inta_fall is ignored.
  - REQ: INT=1, held even if the request is withdrawn. On inta_fall:
    - Re-evaluate; winner=pend_hi if pending, else spurious (level=7).
    - Non-spurious: ISR[winner]<=1 and irr_clear<=onehot(winner) for one cycle.
    - Spurious: no ISR change and irr_clear=0.
    - INT<=0; latch level and spurious; go to ACK1.
  - ACK1: on inta_rise, go to GAP.
  - GAP: on inta_fall, go to ACK2 with data_out<={vector_base,level} and data_oe<=1 at that same edge.
  - ACK2: hold data_out and data_oe. On inta_rise: data_oe<=0 and data_out<=0. If aeoi and not spurious, ISR[level]<=0; if rot_aeoi also set, lowest<=level. Then go to IDLE.
- EOI (eoi_valid=1, accepted in any state):
  - Non-specific: clears isr_hi; no effect if ISR=0.
  - Specific: clears ISR[eoi_level], whether or not it is set.
  - eoi_rotate: lowest<=cleared level. For non-specific with ISR=0, lowest is unchanged.
  - Uses ISR and lowest as they stand before this cycle's updates.
- Simultaneous events in one cycle:
  - ISR set and an EOI/AEOI clear of the same bit: set wins.
  - Different bits: both apply.
  - EOI rotation and AEOI rotation: EOI rotation wins.
- Mask or IRR changes while in REQ: evaluation happens only at inta_fall, so a masked-out request yields a spurious IR7.
- Reset mid-handshake: returns to IDLE with all outputs cleared. Later INTA pulses are ignored in IDLE. data_oe never asserts from a stale handshake.

Test Plan:
- Basic acknowledge: reset; IRR=0x04, Mask=0x00, vector_base=5'b01000.
  - INT=1 one cycle later.
  - First INTA low: ISR=0x04, irr_clear=0x04 for exactly one cycle, INT=0.
  - Second INTA low: data_out=0x42, data_oe=1 only while inta_n low, then 0.
- Nesting: ISR=0x04 in service.
  - IRR=0x10: INT stays 0.
  - IRR=0x01: INT=1; after acknowledge ISR=0x05, vector 0x40.
- Non-specific EOI with ISR=0x05: ISR becomes 0x04, then 0x00; a third EOI changes nothing. Specific EOI level 2 on ISR=0x04 gives 0x00.
- Spurious: IRR=0x08 raises INT; set Mask=0x08 before the first INTA. ISR unchanged, irr_clear=0, vector 0x47.
- AEOI with rotation: aeoi=1, rot_aeoi=1, IRR=0x01 acknowledged.
  - ISR=0x00 after the second INTA rises; lowest=0.
  - Next IRR=0x03: vector level 1, irr_clear=0x02.
- Reset in GAP: ISR=0, INT=0, data_oe=0; the following INTA pulse leaves data_oe=0 and ISR=0.

Source files
------------

// File: rtl/pic_int_sequencer_if.sv
// Bus bundle between the PIC interrupt sequencer and its neighbours:
// IRR/IMR inputs, ICW/OCW control, the INTA handshake and the vector bus.
interface pic_int_sequencer_if;
  logic [7:0] IRR;
  logic [7:0] Mask;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       rot_aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       inta_n;
  logic       INT;
  logic [7:0] irr_clear;
  logic [7:0] ISR;
  logic [7:0] data_out;
  logic       data_oe;

  modport slave (
    input  IRR, Mask, vector_base, aeoi, rot_aeoi,
    input  eoi_valid, eoi_specific, eoi_level, eoi_rotate, inta_n,
    output INT, irr_clear, ISR, data_out, data_oe
  );

  modport master (
    output IRR, Mask, vector_base, aeoi, rot_aeoi,
    output eoi_valid, eoi_specific, eoi_level, eoi_rotate, inta_n,
    input  INT, irr_clear, ISR, data_out, data_oe
  );
endinterface

// File: rtl/pic_int_sequencer.sv
// 8259-style interrupt sequencer: rotating priority resolution against ISR,
// two-pulse INTA handshake, ISR set/clear (EOI and AEOI) and vector output.
module pic_int_sequencer #(
  parameter logic [2:0] RESET_LOWEST = 3'd7
) (
  input logic              clk,
  input logic              reset_n,
  pic_int_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK1, S_GAP, S_ACK2} state_t;

  state_t     r_state, w_state_n;
  logic       r_int, w_int_n;
  logic [7:0] r_irr_clear, w_irr_clear_n;
  logic [7:0] r_isr, w_isr_n;
  logic [7:0] r_data_out, w_data_out_n;
  logic       r_data_oe, w_data_oe_n;
  logic [2:0] r_lowest, w_lowest_n;
  logic [2:0] r_level, w_level_n;
  logic       r_spur, w_spur_n;
  logic       r_inta_prev;

  logic [7:0] w_req, w_isr_set, w_isr_clr;
  logic [2:0] w_pend_hi, w_isr_hi;
  logic       w_pending, w_fall, w_rise;

  // Position in the priority order; 0 is the level just after 'low'.
  function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] low);
    return lvl - low - 3'd1;
  endfunction

  // Highest-priority set bit; scanning from the far end lets the nearest win.
  function automatic logic [2:0] f_top(input logic [7:0] v, input logic [2:0] low);
    logic [2:0] idx;
    f_top = low;
    for (int i = 8; i >= 1; i--) begin
      idx = low + 3'(i);
      if (v[idx]) f_top = idx;
    end
  endfunction

  function automatic logic [7:0] f_onehot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

  always_comb begin
    w_req     = bus.IRR & ~bus.Mask;
    w_pend_hi = f_top(w_req, r_lowest);
    w_isr_hi  = f_top(r_isr, r_lowest);
    w_pending = (|w_req) &&
                (~|r_isr || (f_rank(w_pend_hi, r_lowest) < f_rank(w_isr_hi, r_lowest)));
    w_fall    = r_inta_prev & ~bus.inta_n;
    w_rise    = ~r_inta_prev & bus.inta_n;
  end

  always_comb begin
    w_state_n     = r_state;
    w_int_n       = 1'b0;
    w_irr_clear_n = '0;
    w_data_out_n  = r_data_out;
    w_data_oe_n   = r_data_oe;
    w_level_n     = r_level;
    w_spur_n      = r_spur;
    w_lowest_n    = r_lowest;
    w_isr_set     = '0;
    w_isr_clr     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_state_n = S_REQ;
          w_int_n   = 1'b1;
        end
      end
      S_REQ: begin
        w_int_n = 1'b1;
        if (w_fall) begin
          w_int_n   = 1'b0;
          w_state_n = S_ACK1;
          if (w_pending) begin
            w_level_n     = w_pend_hi;
            w_spur_n      = 1'b0;
            w_isr_set     = f_onehot(w_pend_hi);
            w_irr_clear_n = f_onehot(w_pend_hi);
          end else begin
            w_level_n = 3'd7;
            w_spur_n  = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (w_rise) w_state_n = S_GAP;
      end
      S_GAP: begin
        if (w_fall) begin
          w_state_n    = S_ACK2;
          w_data_out_n = {bus.vector_base, r_level};
          w_data_oe_n  = 1'b1;
        end
      end
      S_ACK2: begin
        if (w_rise) begin
          w_state_n    = S_IDLE;
          w_data_out_n = '0;
          w_data_oe_n  = 1'b0;
          if (bus.aeoi && !r_spur) begin
            w_isr_clr = f_onehot(r_level);
            if (bus.rot_aeoi) w_lowest_n = r_level;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // EOI sits after AEOI so its rotation takes precedence.
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        w_isr_clr = w_isr_clr | f_onehot(bus.eoi_level);
        if (bus.eoi_rotate) w_lowest_n = bus.eoi_level;
      end else if (|r_isr) begin
        w_isr_clr = w_isr_clr | f_onehot(w_isr_hi);
        if (bus.eoi_rotate) w_lowest_n = w_isr_hi;
      end
    end

    w_isr_n = (r_isr & ~w_isr_clr) | w_isr_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_int       <= 1'b0;
      r_irr_clear <= '0;
      r_isr       <= '0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
      r_lowest    <= RESET_LOWEST;
      r_level     <= 3'd0;
      r_spur      <= 1'b0;
      r_inta_prev <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_int       <= w_int_n;
      r_irr_clear <= w_irr_clear_n;
      r_isr       <= w_isr_n;
      r_data_out  <= w_data_out_n;
      r_data_oe   <= w_data_oe_n;
      r_lowest    <= w_lowest_n;
      r_level     <= w_level_n;
      r_spur      <= w_spur_n;
      r_inta_prev <= bus.inta_n;
    end
  end

  assign bus.INT       = r_int;
  assign bus.irr_clear = r_irr_clear;
  assign bus.ISR       = r_isr;
  assign bus.data_out  = r_data_out;
  assign bus.data_oe   = r_data_oe;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Scoreboard bench for pic_int_sequencer: directed scenarios plus randomized
// requests, masks and EOIs against a priority-rank reference model.
module tb_pic_int_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pic_int_sequencer_if bus();

  pic_int_sequencer #(.RESET_LOWEST(3'd7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q_clr[$];
  logic [7:0] q_vec[$];
  bit mon_en = 0;
  logic prev_oe = 1'b0;

  // Reference state
  logic [7:0] m_isr;
  int         m_lowest;
  int         m_level;
  bit         m_spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Rank 0 is the level right after the lowest-priority pointer.
  function automatic int rank(int lvl, int low);
    return (lvl - low + 8 - 1) % 8;
  endfunction

  function automatic int top(logic [7:0] v, int low);
    int best = -1;
    for (int l = 0; l < 8; l++)
      if (v[l] && (best < 0 || rank(l, low) < rank(best, low))) best = l;
    return best;
  endfunction

  function automatic bit m_pending();
    logic [7:0] req;
    req = bus.IRR & ~bus.Mask;
    if (req == 8'h00) return 1'b0;
    if (m_isr == 8'h00) return 1'b1;
    return rank(top(req, m_lowest), m_lowest) < rank(top(m_isr, m_lowest), m_lowest);
  endfunction

  // Monitor: every irr_clear pulse and every vector drive must match a queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.irr_clear !== 8'h00) begin
        if (q_clr.size() == 0) chk("irr_clear_unexpected", 32'(bus.irr_clear), 32'h0);
        else chk("irr_clear", 32'(bus.irr_clear), 32'(q_clr.pop_front()));
      end
      if (bus.data_oe === 1'b1 && prev_oe !== 1'b1) begin
        if (q_vec.size() == 0) chk("data_oe_unexpected", 32'(bus.data_oe), 32'h0);
        else chk("vector", 32'(bus.data_out), 32'(q_vec.pop_front()));
      end
    end
    prev_oe = bus.data_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    reset_n = 1'b0;
    bus.inta_n = 1'b1;
    bus.eoi_valid = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    m_isr = 8'h00;
    m_lowest = 7;
  endtask

  task automatic set_irr(input logic [7:0] irr, input logic [7:0] mask, input string nm,
                         output bit exp);
    bus.IRR = irr;
    bus.Mask = mask;
    exp = m_pending();
    tick;
    chk(nm, 32'(bus.INT), 32'(exp));
  endtask

  // Full two-pulse acknowledge starting from REQ; mask_fall is applied at the first INTA.
  task automatic do_ack(input logic [7:0] mask_fall);
    logic [7:0] oh;
    bus.Mask = mask_fall;
    bus.inta_n = 1'b0;
    if (m_pending()) begin
      m_level = top(bus.IRR & ~bus.Mask, m_lowest);
      m_spur = 1'b0;
      oh = 8'h01 << m_level;
      q_clr.push_back(oh);
      m_isr = m_isr | oh;
    end else begin
      m_level = 7;
      m_spur = 1'b1;
    end
    tick;
    chk("int_after_inta1", 32'(bus.INT), 32'h0);
    chk("isr_after_inta1", 32'(bus.ISR), 32'(m_isr));
    tick;
    bus.inta_n = 1'b1;
    tick;
    tick;
    bus.inta_n = 1'b0;
    q_vec.push_back({bus.vector_base, 3'(m_level)});
    tick;
    chk("data_oe_on", 32'(bus.data_oe), 32'h1);
    tick;
    chk("data_oe_hold", 32'(bus.data_oe), 32'h1);
    bus.inta_n = 1'b1;
    bus.IRR = 8'h00;
    tick;
    chk("data_oe_off", 32'(bus.data_oe), 32'h0);
    chk("data_out_off", 32'(bus.data_out), 32'h0);
    if (bus.aeoi && !m_spur) begin
      m_isr = m_isr & ~(8'h01 << m_level);
      if (bus.rot_aeoi) m_lowest = m_level;
    end
    chk("isr_after_ack", 32'(bus.ISR), 32'(m_isr));
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
    int h;
    bus.eoi_valid = 1'b1;
    bus.eoi_specific = spec;
    bus.eoi_level = lvl;
    bus.eoi_rotate = rot;
    if (spec) begin
      m_isr = m_isr & ~(8'h01 << lvl);
      if (rot) m_lowest = int'(lvl);
    end else if (m_isr != 8'h00) begin
      h = top(m_isr, m_lowest);
      m_isr = m_isr & ~(8'h01 << h);
      if (rot) m_lowest = h;
    end
    tick;
    bus.eoi_valid = 1'b0;
    chk("isr_after_eoi", 32'(bus.ISR), 32'(m_isr));
  endtask

  initial begin
    bit p;
    logic [7:0] irr, mask, mfall;
    bus.IRR = 8'h00;
    bus.Mask = 8'h00;
    bus.vector_base = 5'b01000;
    bus.aeoi = 1'b0;
    bus.rot_aeoi = 1'b0;
    bus.eoi_valid = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_level = 3'd0;
    bus.eoi_rotate = 1'b0;
    bus.inta_n = 1'b1;
    reset_n = 1'b0;
    m_level = 0;
    m_spur = 1'b0;

    do_reset;
    mon_en = 1;
    chk("reset_INT", 32'(bus.INT), 32'h0);
    chk("reset_ISR", 32'(bus.ISR), 32'h0);
    chk("reset_irr_clear", 32'(bus.irr_clear), 32'h0);
    chk("reset_data_out", 32'(bus.data_out), 32'h0);
    chk("reset_data_oe", 32'(bus.data_oe), 32'h0);

    // Basic acknowledge of IR2
    set_irr(8'h04, 8'h00, "int_basic", p);
    do_ack(8'h00);
    chk("isr_basic", 32'(bus.ISR), 32'h04);

    // Nesting: IR4 blocked by IR2 in service, IR0 nests
    set_irr(8'h10, 8'h00, "int_nest_lower", p);
    tick;
    chk("int_nest_lower_hold", 32'(bus.INT), 32'h0);
    set_irr(8'h01, 8'h00, "int_nest_higher", p);
    do_ack(8'h00);
    chk("isr_nest", 32'(bus.ISR), 32'h05);

    // EOIs
    do_eoi(1'b0, 3'd0, 1'b0);
    chk("isr_eoi1", 32'(bus.ISR), 32'h04);
    do_eoi(1'b0, 3'd0, 1'b0);
    chk("isr_eoi2", 32'(bus.ISR), 32'h00);
    do_eoi(1'b0, 3'd0, 1'b0);
    set_irr(8'h04, 8'h00, "int_for_specific", p);
    do_ack(8'h00);
    do_eoi(1'b1, 3'd2, 1'b0);
    chk("isr_specific", 32'(bus.ISR), 32'h00);

    // Spurious: request masked before the first INTA
    set_irr(8'h08, 8'h00, "int_spurious", p);
    do_ack(8'h08);
    chk("isr_spurious", 32'(bus.ISR), 32'h00);
    bus.Mask = 8'h00;
    tick;

    // AEOI with rotation
    bus.aeoi = 1'b1;
    bus.rot_aeoi = 1'b1;
    set_irr(8'h01, 8'h00, "int_aeoi", p);
    do_ack(8'h00);
    chk("isr_aeoi", 32'(bus.ISR), 32'h00);
    set_irr(8'h03, 8'h00, "int_aeoi_rot", p);
    do_ack(8'h00);
    bus.aeoi = 1'b0;
    bus.rot_aeoi = 1'b0;

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      bus.aeoi = 1'($urandom_range(0, 1));
      bus.rot_aeoi = 1'($urandom_range(0, 1));
      bus.vector_base = 5'($urandom);
      irr = 8'($urandom);
      mask = 8'($urandom) & 8'($urandom);
      set_irr(irr, mask, "int_rand", p);
      if (p) begin
        mfall = ($urandom_range(0, 3) == 0) ? 8'($urandom) : mask;
        do_ack(mfall);
      end
      bus.IRR = 8'h00;
      if ($urandom_range(0, 1) == 1)
        do_eoi(1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom_range(0, 1)));
      else
        tick;
    end
    bus.aeoi = 1'b0;
    bus.rot_aeoi = 1'b0;
    bus.Mask = 8'h00;
    bus.vector_base = 5'b01000;

    // Reset while in GAP; later INTA pulses must not drive the bus
    do_reset;
    set_irr(8'h04, 8'h00, "int_gap", p);
    bus.inta_n = 1'b0;
    q_clr.push_back(8'h04);
    tick;
    tick;
    bus.inta_n = 1'b1;
    bus.IRR = 8'h00;
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    m_isr = 8'h00;
    m_lowest = 7;
    chk("gap_reset_ISR", 32'(bus.ISR), 32'h0);
    chk("gap_reset_INT", 32'(bus.INT), 32'h0);
    chk("gap_reset_data_oe", 32'(bus.data_oe), 32'h0);
    bus.inta_n = 1'b0;
    tick;
    tick;
    chk("gap_stale_data_oe", 32'(bus.data_oe), 32'h0);
    bus.inta_n = 1'b1;
    tick;
    tick;
    chk("gap_stale_ISR", 32'(bus.ISR), 32'h0);
    chk("gap_stale_data_oe2", 32'(bus.data_oe), 32'h0);

    tick;
    chk("q_clr_drained", 32'(q_clr.size()), 32'h0);
    chk("q_vec_drained", 32'(q_vec.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
